ysyx_23060332_ifu: RTL and testbench
====================================

Name: ysyx_23060332_ifu

Overview:
- Instruction fetch unit; the producer side of the decoder's `inst_i`/`inst_addr` interface.
- Owns the PC and issues word fetches to instruction memory over a valid/ready request and valid-only response channel.
- Presents one fetched instruction at a time to the IDU with a valid/ready handshake.
- Accepts PC redirects (jal/jalr targets) from the EXU.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, value driven on inst_o when no valid instruction is held.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_addr  output  32  fetch address, word-aligned.
- imem_rsp_valid  input  1  response data valid; exactly one per accepted request.
- imem_rdata  input  32  fetched instruction word.
- inst_valid  output  1  inst_o/inst_addr valid to IDU.
- inst_ready  input  1  IDU/EXU consumes the instruction this cycle.
- inst_o  output  32  instruction to IDU.
- inst_addr  output  32  PC of inst_o.
- redirect_valid  input  1  EXU requests a jump.
- redirect_addr  input  32  jump target.
- fetch_cnt  output  32  count of instructions delivered (inst_valid & inst_ready).
- fetch_err  output  1  misaligned-redirect error (see Optional Feature).

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - pc = RESET_PC; state = S_IDLE.
  - imem_req_valid = 0; imem_addr = RESET_PC.
  - inst_valid = 0; inst_o = NOP_INST; inst_addr = RESET_PC.
  - kill = 0; fetch_cnt = 0; fetch_err = 0.
- States:
  - S_IDLE: one cycle after reset release, then -> S_REQ.
  - S_REQ: imem_req_valid = 1, imem_addr = pc. Address and valid are held stable until imem_req_ready. On imem_req_ready -> S_WAIT.
  - S_WAIT: imem_req_valid = 0. On imem_rsp_valid:
    - kill = 0: latch inst_o = imem_rdata, inst_addr = pc, -> S_HOLD.
    - kill = 1: discard the data, clear kill, -> S_REQ.
    - A response with imem_rsp_valid in the same cycle as the request handshake is not legal; minimum memory latency is 1 cycle.
  - S_HOLD: inst_valid = 1. On inst_ready: pc <= redirect_valid ? redirect_addr : pc + 4, fetch_cnt += 1, -> S_REQ. inst_valid drops the next cycle; inst_o returns to NOP_INST.
- Latency: with a 1-cycle memory, steady-state throughput is one instruction per 3 cycles (REQ, WAIT, HOLD). inst_valid rises 1 cycle after rsp_valid.
- Redirect handling (redirect_valid sampled every cycle):
  - S_IDLE: pc <= redirect_addr.
  - S_REQ before acceptance: the request stays stable. Record pc <= redirect_addr and set kill; the in-flight fetch is discarded after acceptance and re-issued at the new pc.
  - S_REQ with imem_req_ready in the same cycle: same as above (kill set, pc updated).
  - S_WAIT: pc <= redirect_addr, kill = 1; the response, including one arriving this cycle, is discarded, -> S_REQ.
  - S_HOLD without inst_ready: the held instruction is dropped (inst_valid = 0 next cycle, no count), pc <= redirect_addr, -> S_REQ.
  - Multiple redirects before refetch: the last one wins.
- Arithmetic: pc + 4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0. fetch_cnt wraps modulo 2^32.
- Reset mid-operation: all state is abandoned immediately. An outstanding memory response arriving after reset is ignored because state is S_IDLE/S_REQ; memory is reset on the same `rst`.
- In S_HOLD, inst_o and inst_addr are stable until the handshake or a redirect.

Optional Feature:
- Macro: IFU_MISALIGN_CHK_EN.
- Defined: a redirect with redirect_addr[1:0] != 0 sets fetch_err = 1 (sticky until rst) and moves to S_ERR. In S_ERR: no requests, inst_valid = 0, other outputs hold. The misaligned address is stored to inst_addr for debug.
- Undefined: redirect_addr[1:0] is forced to 2'b00 when loaded into pc; fetch_err is tied 0 and no S_ERR state exists.

Test Plan:
1. Reset release, memory 1-cycle, rdata = 32'h00100093, inst_ready = 1 -> first imem_addr = 32'h8000_0000; inst_valid with inst_o = 32'h00100093, inst_addr = 32'h8000_0000; next request at 32'h8000_0004; fetch_cnt = 1.
2. inst_ready held 0 for 5 cycles in S_HOLD -> inst_o/inst_addr stable, no new imem_req_valid; fetch_cnt unchanged until the handshake.
3. Redirect in S_HOLD with inst_ready = 1, redirect_addr = 32'h8000_0100 -> next imem_addr = 32'h8000_0100; fetch_cnt increments.
4. Redirect to 32'h8000_0200 during S_WAIT, response arrives same cycle with 32'hDEADBEEF -> DEADBEEF never presented; next request at 32'h8000_0200.
5. imem_req_ready low 3 cycles while a redirect pulses in S_REQ -> imem_addr unchanged until accepted; the returned word is discarded; refetch at the redirect target.
6. pc = 32'hFFFF_FFFC handshake -> next imem_addr = 32'h0000_0000. With IFU_MISALIGN_CHK_EN, redirect to 32'h8000_0002 -> fetch_err = 1, no further requests. Without the macro, the fetch goes to 32'h8000_0000.

Source files
------------

// File: rtl/ysyx_23060332_ifu_if.sv
// Bundle of the IFU's memory-fetch, IDU-delivery and redirect signals.
// master = IFU side, slave = memory/IDU/EXU side.
interface ysyx_23060332_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_o;
  logic [31:0] inst_addr;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic [31:0] fetch_cnt;
  logic        fetch_err;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rdata,
    output inst_valid, inst_o, inst_addr,
    input  inst_ready, redirect_valid, redirect_addr,
    output fetch_cnt, fetch_err
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rdata,
    input  inst_valid, inst_o, inst_addr,
    output inst_ready, redirect_valid, redirect_addr,
    input  fetch_cnt, fetch_err
  );
endinterface

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: PC owner, one outstanding word fetch, one held instruction.
// Optional macro IFU_MISALIGN_CHK_EN traps misaligned redirects into a sticky error state.
module ysyx_23060332_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input logic                 clk,
  input logic                 rst,
  ysyx_23060332_ifu_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
`ifdef IFU_MISALIGN_CHK_EN
    S_HOLD = 3'd3,
    S_ERR  = 3'd4
`else
    S_HOLD = 3'd3
`endif
  } state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic        r_kill;
  logic        r_req_valid;
  logic [31:0] r_req_addr;
  logic        r_inst_valid;
  logic [31:0] r_inst;
  logic [31:0] r_inst_addr;
  logic [31:0] r_fetch_cnt;
  logic        r_fetch_err;

  logic [31:0] w_redir_pc;
  logic [31:0] w_keep_next;
  logic [31:0] w_hold_next;
`ifdef IFU_MISALIGN_CHK_EN
  logic        w_misalign;
`endif

  // Next-PC candidates; without the checker the low bits of a target are dropped.
  always_comb begin
`ifdef IFU_MISALIGN_CHK_EN
    w_redir_pc = bus.redirect_addr;
    w_misalign = bus.redirect_valid && (bus.redirect_addr[1:0] != 2'b00);
`else
    w_redir_pc = {bus.redirect_addr[31:2], 2'b00};
`endif
    if (bus.redirect_valid) begin
      w_keep_next = w_redir_pc;
      w_hold_next = w_redir_pc;
    end else begin
      w_keep_next = r_pc;
      w_hold_next = r_pc + 32'd4;
    end
  end

  // Fetch FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_kill       <= 1'b0;
      r_req_valid  <= 1'b0;
      r_req_addr   <= RESET_PC;
      r_inst_valid <= 1'b0;
      r_inst       <= NOP_INST;
      r_inst_addr  <= RESET_PC;
      r_fetch_cnt  <= 32'd0;
      r_fetch_err  <= 1'b0;
    end else begin
`ifdef IFU_MISALIGN_CHK_EN
      if (w_misalign && (r_state != S_ERR)) begin
        r_state      <= S_ERR;
        r_fetch_err  <= 1'b1;
        r_req_valid  <= 1'b0;
        r_inst_valid <= 1'b0;
        r_inst       <= NOP_INST;
        r_inst_addr  <= bus.redirect_addr;
        if ((r_state == S_HOLD) && bus.inst_ready) begin
          r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end else begin
          r_fetch_cnt <= r_fetch_cnt;
        end
      end else
`endif
      begin
        case (r_state)
          S_IDLE: begin
            r_pc        <= w_keep_next;
            r_req_addr  <= w_keep_next;
            r_req_valid <= 1'b1;
            r_state     <= S_REQ;
          end
          S_REQ: begin
            // The request itself stays frozen; a redirect only retargets the refetch.
            if (bus.redirect_valid) begin
              r_pc   <= w_redir_pc;
              r_kill <= 1'b1;
            end else begin
              r_pc   <= r_pc;
              r_kill <= r_kill;
            end
            if (bus.imem_req_ready) begin
              r_req_valid <= 1'b0;
              r_state     <= S_WAIT;
            end else begin
              r_req_valid <= 1'b1;
              r_state     <= S_REQ;
            end
          end
          S_WAIT: begin
            if (bus.imem_rsp_valid) begin
              if (r_kill || bus.redirect_valid) begin
                r_kill      <= 1'b0;
                r_pc        <= w_keep_next;
                r_req_addr  <= w_keep_next;
                r_req_valid <= 1'b1;
                r_state     <= S_REQ;
              end else begin
                r_inst       <= bus.imem_rdata;
                r_inst_addr  <= r_pc;
                r_inst_valid <= 1'b1;
                r_state      <= S_HOLD;
              end
            end else if (bus.redirect_valid) begin
              r_pc   <= w_redir_pc;
              r_kill <= 1'b1;
            end else begin
              r_state <= S_WAIT;
            end
          end
          S_HOLD: begin
            if (bus.inst_ready) begin
              r_fetch_cnt  <= r_fetch_cnt + 32'd1;
              r_pc         <= w_hold_next;
              r_req_addr   <= w_hold_next;
              r_req_valid  <= 1'b1;
              r_inst_valid <= 1'b0;
              r_inst       <= NOP_INST;
              r_state      <= S_REQ;
            end else if (bus.redirect_valid) begin
              r_pc         <= w_redir_pc;
              r_req_addr   <= w_redir_pc;
              r_req_valid  <= 1'b1;
              r_inst_valid <= 1'b0;
              r_inst       <= NOP_INST;
              r_state      <= S_REQ;
            end else begin
              r_state <= S_HOLD;
            end
          end
`ifdef IFU_MISALIGN_CHK_EN
          S_ERR: begin
            r_state      <= S_ERR;
            r_req_valid  <= 1'b0;
            r_inst_valid <= 1'b0;
          end
`endif
          default: begin
            r_state      <= S_IDLE;
            r_kill       <= 1'b0;
            r_req_valid  <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= NOP_INST;
          end
        endcase
      end
    end
  end

  assign bus.imem_req_valid = r_req_valid;
  assign bus.imem_addr      = r_req_addr;
  assign bus.inst_valid     = r_inst_valid;
  assign bus.inst_o         = r_inst;
  assign bus.inst_addr      = r_inst_addr;
  assign bus.fetch_cnt      = r_fetch_cnt;
`ifdef IFU_MISALIGN_CHK_EN
  assign bus.fetch_err      = r_fetch_err;
`else
  assign bus.fetch_err      = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Directed bench for ysyx_23060332_ifu with a 1-cycle instruction memory model.
module tb_ysyx_23060332_ifu;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   force_dead;
  bit   acc;
  logic [31:0] acc_addr;

  ysyx_23060332_ifu_if bus_if ();

  ysyx_23060332_ifu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (force_dead) return 32'hDEAD_BEEF;
    if (a == 32'h8000_0000) return 32'h0010_0093;
    return a ^ 32'h1357_0000;
  endfunction

  // Memory: a request accepted at an edge is answered during the following cycle.
  initial begin
    bus_if.imem_rsp_valid = 1'b0;
    bus_if.imem_rdata     = 32'h0;
    forever begin
      @(negedge clk);
      acc      = bus_if.imem_req_valid && bus_if.imem_req_ready && !rst;
      acc_addr = bus_if.imem_addr;
      @(posedge clk);
      #1;
      bus_if.imem_rsp_valid = acc;
      bus_if.imem_rdata     = acc ? mem_word(acc_addr) : 32'h0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    checks += 7;
    if (bus_if.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %h exp 0", bus_if.imem_req_valid); end
    if (bus_if.imem_addr !== 32'h8000_0000) begin errors++; $display("FAIL rst_addr got %h exp 80000000", bus_if.imem_addr); end
    if (bus_if.inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid got %h exp 0", bus_if.inst_valid); end
    if (bus_if.inst_o !== 32'h0000_0013) begin errors++; $display("FAIL rst_inst_o got %h exp 00000013", bus_if.inst_o); end
    if (bus_if.inst_addr !== 32'h8000_0000) begin errors++; $display("FAIL rst_inst_addr got %h exp 80000000", bus_if.inst_addr); end
    if (bus_if.fetch_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got %h exp 0", bus_if.fetch_cnt); end
    if (bus_if.fetch_err !== 1'b0) begin errors++; $display("FAIL rst_err got %h exp 0", bus_if.fetch_err); end
  endtask

  task automatic test_basic;
    bus_if.inst_ready = 1'b1;
    rst = 1'b0;
    tick();
    checks += 2;
    if (bus_if.imem_req_valid !== 1'b1) begin errors++; $display("FAIL basic_req_valid got %h exp 1", bus_if.imem_req_valid); end
    if (bus_if.imem_addr !== 32'h8000_0000) begin errors++; $display("FAIL basic_addr0 got %h exp 80000000", bus_if.imem_addr); end
    tick();
    checks += 1;
    if (bus_if.imem_req_valid !== 1'b0) begin errors++; $display("FAIL basic_wait_req got %h exp 0", bus_if.imem_req_valid); end
    tick();
    checks += 3;
    if (bus_if.inst_valid !== 1'b1) begin errors++; $display("FAIL basic_inst_valid got %h exp 1", bus_if.inst_valid); end
    if (bus_if.inst_o !== 32'h0010_0093) begin errors++; $display("FAIL basic_inst_o got %h exp 00100093", bus_if.inst_o); end
    if (bus_if.inst_addr !== 32'h8000_0000) begin errors++; $display("FAIL basic_inst_addr got %h exp 80000000", bus_if.inst_addr); end
    tick();
    checks += 5;
    if (bus_if.imem_req_valid !== 1'b1) begin errors++; $display("FAIL basic_req2 got %h exp 1", bus_if.imem_req_valid); end
    if (bus_if.imem_addr !== 32'h8000_0004) begin errors++; $display("FAIL basic_addr1 got %h exp 80000004", bus_if.imem_addr); end
    if (bus_if.fetch_cnt !== 32'd1) begin errors++; $display("FAIL basic_cnt got %0d exp 1", bus_if.fetch_cnt); end
    if (bus_if.inst_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %h exp 0", bus_if.inst_valid); end
    if (bus_if.inst_o !== 32'h0000_0013) begin errors++; $display("FAIL basic_nop got %h exp 00000013", bus_if.inst_o); end
  endtask

  task automatic test_stall;
    bus_if.inst_ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      checks += 5;
      if (bus_if.inst_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %h exp 1", i, bus_if.inst_valid); end
      if (bus_if.inst_o !== 32'h9357_0004) begin errors++; $display("FAIL stall_inst_o[%0d] got %h exp 93570004", i, bus_if.inst_o); end
      if (bus_if.inst_addr !== 32'h8000_0004) begin errors++; $display("FAIL stall_inst_addr[%0d] got %h exp 80000004", i, bus_if.inst_addr); end
      if (bus_if.imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_no_req[%0d] got %h exp 0", i, bus_if.imem_req_valid); end
      if (bus_if.fetch_cnt !== 32'd1) begin errors++; $display("FAIL stall_cnt[%0d] got %0d exp 1", i, bus_if.fetch_cnt); end
      tick();
    end
    bus_if.inst_ready = 1'b1;
    tick();
    checks += 2;
    if (bus_if.fetch_cnt !== 32'd2) begin errors++; $display("FAIL stall_cnt_after got %0d exp 2", bus_if.fetch_cnt); end
    if (bus_if.imem_addr !== 32'h8000_0008) begin errors++; $display("FAIL stall_next_addr got %h exp 80000008", bus_if.imem_addr); end
  endtask

  task automatic test_redirect_hold;
    bus_if.inst_ready = 1'b0;
    tick();
    tick();
    checks += 1;
    if (bus_if.inst_addr !== 32'h8000_0008) begin errors++; $display("FAIL rh_inst_addr got %h exp 80000008", bus_if.inst_addr); end
    bus_if.inst_ready     = 1'b1;
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_addr  = 32'h8000_0100;
    tick();
    bus_if.redirect_valid = 1'b0;
    bus_if.inst_ready     = 1'b0;
    checks += 3;
    if (bus_if.imem_addr !== 32'h8000_0100) begin errors++; $display("FAIL rh_addr got %h exp 80000100", bus_if.imem_addr); end
    if (bus_if.imem_req_valid !== 1'b1) begin errors++; $display("FAIL rh_req got %h exp 1", bus_if.imem_req_valid); end
    if (bus_if.fetch_cnt !== 32'd3) begin errors++; $display("FAIL rh_cnt got %0d exp 3", bus_if.fetch_cnt); end
    tick();
    tick();
    checks += 2;
    if (bus_if.inst_addr !== 32'h8000_0100) begin errors++; $display("FAIL rh_tgt_addr got %h exp 80000100", bus_if.inst_addr); end
    if (bus_if.inst_o !== 32'h9357_0100) begin errors++; $display("FAIL rh_tgt_inst got %h exp 93570100", bus_if.inst_o); end
    // Redirect without handshake drops the held instruction uncounted.
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_addr  = 32'h8000_0300;
    tick();
    bus_if.redirect_valid = 1'b0;
    checks += 4;
    if (bus_if.inst_valid !== 1'b0) begin errors++; $display("FAIL rh_drop_valid got %h exp 0", bus_if.inst_valid); end
    if (bus_if.imem_req_valid !== 1'b1) begin errors++; $display("FAIL rh_drop_req got %h exp 1", bus_if.imem_req_valid); end
    if (bus_if.imem_addr !== 32'h8000_0300) begin errors++; $display("FAIL rh_drop_addr got %h exp 80000300", bus_if.imem_addr); end
    if (bus_if.fetch_cnt !== 32'd3) begin errors++; $display("FAIL rh_drop_cnt got %0d exp 3", bus_if.fetch_cnt); end
  endtask

  task automatic test_redirect_wait;
    force_dead = 1'b1;
    tick();
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_addr  = 32'h8000_0200;
    tick();
    bus_if.redirect_valid = 1'b0;
    force_dead = 1'b0;
    checks += 3;
    if (bus_if.inst_valid !== 1'b0) begin errors++; $display("FAIL rw_no_valid got %h exp 0", bus_if.inst_valid); end
    if (bus_if.imem_req_valid !== 1'b1) begin errors++; $display("FAIL rw_req got %h exp 1", bus_if.imem_req_valid); end
    if (bus_if.imem_addr !== 32'h8000_0200) begin errors++; $display("FAIL rw_addr got %h exp 80000200", bus_if.imem_addr); end
    tick();
    tick();
    checks += 3;
    if (bus_if.inst_valid !== 1'b1) begin errors++; $display("FAIL rw_valid got %h exp 1", bus_if.inst_valid); end
    if (bus_if.inst_o !== 32'h9357_0200) begin errors++; $display("FAIL rw_inst got %h exp 93570200", bus_if.inst_o); end
    if (bus_if.inst_addr !== 32'h8000_0200) begin errors++; $display("FAIL rw_inst_addr got %h exp 80000200", bus_if.inst_addr); end
    bus_if.inst_ready = 1'b1;
    tick();
    checks += 1;
    if (bus_if.fetch_cnt !== 32'd4) begin errors++; $display("FAIL rw_cnt got %0d exp 4", bus_if.fetch_cnt); end
  endtask

  task automatic test_req_stall;
    bus_if.inst_ready     = 1'b0;
    bus_if.imem_req_ready = 1'b0;
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_addr  = 32'h8000_0500;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus_if.redirect_addr  = 32'h8000_0400;
      bus_if.redirect_valid = (i == 0);
      checks += 2;
      if (bus_if.imem_req_valid !== 1'b1) begin errors++; $display("FAIL rs_req[%0d] got %h exp 1", i, bus_if.imem_req_valid); end
      if (bus_if.imem_addr !== 32'h8000_0204) begin errors++; $display("FAIL rs_addr[%0d] got %h exp 80000204", i, bus_if.imem_addr); end
    end
    bus_if.imem_req_ready = 1'b1;
    tick();
    tick();
    checks += 3;
    if (bus_if.inst_valid !== 1'b0) begin errors++; $display("FAIL rs_discard got %h exp 0", bus_if.inst_valid); end
    if (bus_if.imem_req_valid !== 1'b1) begin errors++; $display("FAIL rs_refetch got %h exp 1", bus_if.imem_req_valid); end
    if (bus_if.imem_addr !== 32'h8000_0400) begin errors++; $display("FAIL rs_tgt got %h exp 80000400", bus_if.imem_addr); end
    tick();
    tick();
    checks += 2;
    if (bus_if.inst_addr !== 32'h8000_0400) begin errors++; $display("FAIL rs_inst_addr got %h exp 80000400", bus_if.inst_addr); end
    if (bus_if.inst_o !== 32'h9357_0400) begin errors++; $display("FAIL rs_inst got %h exp 93570400", bus_if.inst_o); end
    bus_if.inst_ready = 1'b1;
    tick();
    checks += 1;
    if (bus_if.fetch_cnt !== 32'd5) begin errors++; $display("FAIL rs_cnt got %0d exp 5", bus_if.fetch_cnt); end
  endtask

  task automatic test_wrap_misalign;
    tick();
    tick();
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_addr  = 32'hFFFF_FFFC;
    tick();
    bus_if.redirect_valid = 1'b0;
    checks += 2;
    if (bus_if.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top got %h exp fffffffc", bus_if.imem_addr); end
    if (bus_if.fetch_cnt !== 32'd6) begin errors++; $display("FAIL wrap_cnt6 got %0d exp 6", bus_if.fetch_cnt); end
    tick();
    tick();
    checks += 1;
    if (bus_if.inst_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_inst_addr got %h exp fffffffc", bus_if.inst_addr); end
    tick();
    bus_if.inst_ready = 1'b0;
    checks += 3;
    if (bus_if.imem_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_zero got %h exp 00000000", bus_if.imem_addr); end
    if (bus_if.imem_req_valid !== 1'b1) begin errors++; $display("FAIL wrap_req got %h exp 1", bus_if.imem_req_valid); end
    if (bus_if.fetch_cnt !== 32'd7) begin errors++; $display("FAIL wrap_cnt7 got %0d exp 7", bus_if.fetch_cnt); end
    tick();
    tick();
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_addr  = 32'h8000_0002;
    tick();
    bus_if.redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
    for (int i = 0; i < 4; i++) begin
      checks += 4;
      if (bus_if.fetch_err !== 1'b1) begin errors++; $display("FAIL mis_err[%0d] got %h exp 1", i, bus_if.fetch_err); end
      if (bus_if.imem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_no_req[%0d] got %h exp 0", i, bus_if.imem_req_valid); end
      if (bus_if.inst_valid !== 1'b0) begin errors++; $display("FAIL mis_valid[%0d] got %h exp 0", i, bus_if.inst_valid); end
      if (bus_if.inst_addr !== 32'h8000_0002) begin errors++; $display("FAIL mis_dbg_addr[%0d] got %h exp 80000002", i, bus_if.inst_addr); end
      tick();
    end
`else
    checks += 3;
    if (bus_if.fetch_err !== 1'b0) begin errors++; $display("FAIL mis_err got %h exp 0", bus_if.fetch_err); end
    if (bus_if.imem_req_valid !== 1'b1) begin errors++; $display("FAIL mis_req got %h exp 1", bus_if.imem_req_valid); end
    if (bus_if.imem_addr !== 32'h8000_0000) begin errors++; $display("FAIL mis_align got %h exp 80000000", bus_if.imem_addr); end
    tick();
    tick();
    checks += 2;
    if (bus_if.inst_o !== 32'h0010_0093) begin errors++; $display("FAIL mis_inst got %h exp 00100093", bus_if.inst_o); end
    if (bus_if.inst_addr !== 32'h8000_0000) begin errors++; $display("FAIL mis_inst_addr got %h exp 80000000", bus_if.inst_addr); end
`endif
  endtask

  task automatic test_reset_mid;
    rst = 1'b1;
    tick();
    checks += 4;
    if (bus_if.fetch_cnt !== 32'd0) begin errors++; $display("FAIL rm_cnt got %0d exp 0", bus_if.fetch_cnt); end
    if (bus_if.fetch_err !== 1'b0) begin errors++; $display("FAIL rm_err got %h exp 0", bus_if.fetch_err); end
    if (bus_if.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rm_req got %h exp 0", bus_if.imem_req_valid); end
    if (bus_if.inst_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %h exp 0", bus_if.inst_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    force_dead = 1'b0;
    rst = 1'b1;
    bus_if.imem_req_ready = 1'b1;
    bus_if.inst_ready     = 1'b0;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_addr  = 32'h0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_hold();
    test_redirect_wait();
    test_req_stall();
    test_wrap_misalign();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
